// File: rtl/mem_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_arbiter_if
// Brief    : Cache-side and memory-side signal bundle of the memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_bus_arbiter_if #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int BURST_LEN = 4
);
    localparam int BEAT_W = $clog2(BURST_LEN);

    logic              ic_req;
    logic [ADDR_W-1:0] ic_addr;
    logic [DATA_W-1:0] ic_rdata;
    logic              ic_rvalid;
    logic              ic_done;
    logic              ic_err;

    logic              dc_req;
    logic              dc_we;
    logic [ADDR_W-1:0] dc_addr;
    logic [DATA_W-1:0] dc_wdata;
    logic [DATA_W-1:0] dc_rdata;
    logic              dc_rvalid;
    logic              dc_done;
    logic              dc_err;

    logic [BEAT_W-1:0] beat;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_rw;
    logic              mem_en;
    logic              mem_oe;
    logic              mem_ready;

    // master: the arbiter; slave: the caches and memory it connects
    modport master (
        input  ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata, mem_rdata, mem_ready,
        output ic_rdata, ic_rvalid, ic_done, ic_err,
        output dc_rdata, dc_rvalid, dc_done, dc_err,
        output beat, mem_addr, mem_wdata, mem_rw, mem_en, mem_oe
    );

    modport slave (
        output ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata, mem_rdata, mem_ready,
        input  ic_rdata, ic_rvalid, ic_done, ic_err,
        input  dc_rdata, dc_rvalid, dc_done, dc_err,
        input  beat, mem_addr, mem_wdata, mem_rw, mem_en, mem_oe
    );
endinterface
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_arbiter
// Brief    : I/D cache arbiter for one burst memory port, with beat timeout.
// Revision : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int BURST_LEN    = 4,
    parameter int TIMEOUT      = 255,
    parameter int MAX_D_STREAK = 2
) (
    input  wire logic         clk,
    input  wire logic         rst,
    mem_bus_arbiter_if.master bus
);
    localparam int BEAT_W   = $clog2(BURST_LEN);
    localparam int OFS_W    = BEAT_W + 2;
    localparam int WAIT_W   = $clog2(TIMEOUT + 1);
    localparam int STREAK_W = $clog2(MAX_D_STREAK + 1);

    localparam logic [ADDR_W-1:0]   c_LINE_MASK  = ~ADDR_W'((1 << OFS_W) - 1);
    localparam logic [BEAT_W-1:0]   c_LAST_BEAT  = BEAT_W'(BURST_LEN - 1);
    localparam logic [WAIT_W-1:0]   c_WAIT_LAST  = WAIT_W'(TIMEOUT - 1);
    localparam logic [STREAK_W-1:0] c_STREAK_MAX = STREAK_W'(MAX_D_STREAK);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_base;
    logic                r_sel_d;
    logic                r_write;
    logic [BEAT_W-1:0]   r_beat;
    logic [WAIT_W-1:0]   r_wait;
    logic [STREAK_W-1:0] r_streak;

    logic [ADDR_W-1:0]   r_mem_addr;
    logic                r_mem_en;
    logic                r_mem_oe;
    logic                r_mem_rw;
    logic [DATA_W-1:0]   r_ic_rdata;
    logic                r_ic_rvalid;
    logic                r_ic_done;
    logic                r_ic_err;
    logic [DATA_W-1:0]   r_dc_rdata;
    logic                r_dc_rvalid;
    logic                r_dc_done;
    logic                r_dc_err;

    logic                w_any_req;
    logic                w_grant_d;
    logic                w_grant_wr;
    logic [ADDR_W-1:0]   w_grant_base;
    logic                w_last_beat;
    logic [BEAT_W-1:0]   w_beat_nxt;

    // I is only forced in once D has won MAX_D_STREAK times in a row over it
    assign w_any_req    = bus.ic_req | bus.dc_req;
    assign w_grant_d    = bus.dc_req & ~(bus.ic_req & (r_streak == c_STREAK_MAX));
    assign w_grant_wr   = w_grant_d & bus.dc_we;
    assign w_grant_base = (w_grant_d ? bus.dc_addr : bus.ic_addr) & c_LINE_MASK;
    assign w_last_beat  = (r_beat == c_LAST_BEAT);
    assign w_beat_nxt   = r_beat + BEAT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_base      <= '0;
            r_sel_d     <= 1'b0;
            r_write     <= 1'b0;
            r_beat      <= '0;
            r_wait      <= '0;
            r_streak    <= '0;
            r_mem_addr  <= '0;
            r_mem_en    <= 1'b0;
            r_mem_oe    <= 1'b0;
            r_mem_rw    <= 1'b1;
            r_ic_rdata  <= '0;
            r_ic_rvalid <= 1'b0;
            r_ic_done   <= 1'b0;
            r_ic_err    <= 1'b0;
            r_dc_rdata  <= '0;
            r_dc_rvalid <= 1'b0;
            r_dc_done   <= 1'b0;
            r_dc_err    <= 1'b0;
        end else begin
            r_ic_rvalid <= 1'b0;
            r_ic_done   <= 1'b0;
            r_ic_err    <= 1'b0;
            r_dc_rvalid <= 1'b0;
            r_dc_done   <= 1'b0;
            r_dc_err    <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_state    <= BURST;
                        r_sel_d    <= w_grant_d;
                        r_write    <= w_grant_wr;
                        r_base     <= w_grant_base;
                        r_mem_addr <= w_grant_base;
                        r_beat     <= '0;
                        r_wait     <= '0;
                        r_mem_en   <= 1'b1;
                        r_mem_oe   <= w_grant_wr;
                        r_mem_rw   <= ~w_grant_wr;
                        if (w_grant_d && bus.ic_req) begin
                            if (r_streak != c_STREAK_MAX) begin
                                r_streak <= r_streak + STREAK_W'(1);
                            end
                        end else begin
                            r_streak <= '0;
                        end
                    end
                end

                BURST: begin
                    if (bus.mem_ready) begin
                        r_wait <= '0;
                        if (!r_write) begin
                            if (r_sel_d) begin
                                r_dc_rdata  <= bus.mem_rdata;
                                r_dc_rvalid <= 1'b1;
                            end else begin
                                r_ic_rdata  <= bus.mem_rdata;
                                r_ic_rvalid <= 1'b1;
                            end
                        end
                        if (w_last_beat) begin
                            r_state   <= DONE;
                            r_mem_en  <= 1'b0;
                            r_mem_oe  <= 1'b0;
                            r_dc_done <= r_sel_d;
                            r_ic_done <= ~r_sel_d;
                        end else begin
                            r_beat     <= w_beat_nxt;
                            // base is line aligned, so OR-ing the offset keeps the beat in the line
                            r_mem_addr <= r_base | ADDR_W'({w_beat_nxt, 2'b00});
                        end
                    end else if (r_wait == c_WAIT_LAST) begin
                        r_state   <= DONE;
                        r_mem_en  <= 1'b0;
                        r_mem_oe  <= 1'b0;
                        r_dc_done <= r_sel_d;
                        r_dc_err  <= r_sel_d;
                        r_ic_done <= ~r_sel_d;
                        r_ic_err  <= ~r_sel_d;
                    end else begin
                        r_wait <= r_wait + WAIT_W'(1);
                    end
                end

                DONE: begin
                    r_state  <= IDLE;
                    r_mem_rw <= 1'b1;
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.beat      = r_beat;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_en    = r_mem_en;
    assign bus.mem_oe    = r_mem_oe;
    assign bus.mem_rw    = r_mem_rw;
    assign bus.mem_wdata = ((r_state == BURST) && r_write) ? bus.dc_wdata : '0;
    assign bus.ic_rdata  = r_ic_rdata;
    assign bus.ic_rvalid = r_ic_rvalid;
    assign bus.ic_done   = r_ic_done;
    assign bus.ic_err    = r_ic_err;
    assign bus.dc_rdata  = r_dc_rdata;
    assign bus.dc_rvalid = r_dc_rvalid;
    assign bus.dc_done   = r_dc_done;
    assign bus.dc_err    = r_dc_err;
endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_bus_arbiter
// Brief    : Directed self-checking bench for mem_bus_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_bus_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32), .BURST_LEN(4)) bus ();

    mem_bus_arbiter #(
        .ADDR_W(32), .DATA_W(32), .BURST_LEN(4), .TIMEOUT(8), .MAX_D_STREAK(2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // memory returns a word derived from its address; D-cache supplies 0xA0+beat
    assign bus.mem_rdata = 32'hD000_0000 ^ bus.mem_addr;
    assign bus.dc_wdata  = 32'h0000_00A0 + 32'(bus.beat);

    logic [31:0] m_addr[$];
    logic [31:0] m_wdata[$];
    logic [31:0] m_ic_rd[$];
    logic [31:0] m_dc_rd[$];
    int          m_done[$];
    int          m_rw1, m_oe1, m_ic_err, m_dc_err, m_err_alone, m_done_rv;

    // mode 0: ready always high, 1: three low cycles per beat, 2: stuck low
    task automatic run(input int ncyc, input int mode, input int max_done);
        int cnt = 0;
        m_addr.delete(); m_wdata.delete(); m_ic_rd.delete(); m_dc_rd.delete(); m_done.delete();
        m_rw1 = 0; m_oe1 = 0; m_ic_err = 0; m_dc_err = 0; m_err_alone = 0; m_done_rv = 0;
        bus.mem_ready = (mode == 0);
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            if (bus.mem_en) begin
                m_addr.push_back(bus.mem_addr);
                m_wdata.push_back(bus.mem_wdata);
                if (bus.mem_rw) m_rw1++;
                if (bus.mem_oe) m_oe1++;
            end
            if (bus.ic_rvalid) m_ic_rd.push_back(bus.ic_rdata);
            if (bus.dc_rvalid) m_dc_rd.push_back(bus.dc_rdata);
            if (bus.ic_err) m_ic_err++;
            if (bus.dc_err) m_dc_err++;
            if ((bus.ic_err && !bus.ic_done) || (bus.dc_err && !bus.dc_done)) m_err_alone++;
            if ((bus.ic_done && bus.ic_rvalid) || (bus.dc_done && bus.dc_rvalid)) m_done_rv++;
            if (bus.ic_done) m_done.push_back(0);
            if (bus.dc_done) m_done.push_back(1);
            if ((bus.ic_done || bus.dc_done) && m_done.size() >= max_done) begin
                bus.ic_req = 1'b0;
                bus.dc_req = 1'b0;
            end
            if (mode == 1 && bus.mem_en) begin
                if (cnt < 3) begin bus.mem_ready = 1'b0; cnt++; end
                else begin bus.mem_ready = 1'b1; cnt = 0; end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if ({bus.mem_en, bus.mem_oe, bus.mem_rw, bus.ic_rvalid, bus.ic_done, bus.ic_err,
             bus.dc_rvalid, bus.dc_done, bus.dc_err} !== 9'b001000000) begin
            bad++;
            $display("FAIL reset_ctrl got=%b want=001000000", {bus.mem_en, bus.mem_oe, bus.mem_rw,
                     bus.ic_rvalid, bus.ic_done, bus.ic_err, bus.dc_rvalid, bus.dc_done, bus.dc_err});
        end
        total++;
        if ({bus.mem_addr, bus.mem_wdata, bus.ic_rdata, bus.dc_rdata} !== 128'h0 || bus.beat !== 2'd0) begin
            bad++;
            $display("FAIL reset_data addr=%h wdata=%h icrd=%h dcrd=%h beat=%0d want all 0",
                     bus.mem_addr, bus.mem_wdata, bus.ic_rdata, bus.dc_rdata, bus.beat);
        end
        rst = 1'b0;
    endtask

    task automatic test_i_refill();
        logic [31:0] exp_a [4] = '{32'h1230, 32'h1234, 32'h1238, 32'h123C};
        bus.ic_addr = 32'h0000_1234;
        bus.ic_req  = 1'b1;
        run(12, 0, 1);
        total++;
        if (m_addr.size() != 4 || m_ic_rd.size() != 4) begin
            bad++; $display("FAIL irefill_count en=%0d rv=%0d want 4/4", m_addr.size(), m_ic_rd.size());
        end
        for (int k = 0; k < 4; k++) begin
            if (k < m_addr.size()) begin
                total++;
                if (m_addr[k] !== exp_a[k]) begin
                    bad++; $display("FAIL irefill_addr%0d got=%h want=%h", k, m_addr[k], exp_a[k]);
                end
            end
            if (k < m_ic_rd.size()) begin
                total++;
                if (m_ic_rd[k] !== (32'hD000_0000 ^ exp_a[k])) begin
                    bad++; $display("FAIL irefill_rdata%0d got=%h want=%h", k, m_ic_rd[k], 32'hD000_0000 ^ exp_a[k]);
                end
            end
        end
        total++;
        if (m_rw1 != 4 || m_oe1 != 0) begin
            bad++; $display("FAIL irefill_dir rw1=%0d oe1=%0d want 4/0", m_rw1, m_oe1);
        end
        total++;
        if (m_done.size() != 1 || m_done_rv != 1 || m_ic_err != 0 || m_dc_rd.size() != 0) begin
            bad++; $display("FAIL irefill_done dones=%0d done_with_rv=%0d err=%0d dcrv=%0d want 1/1/0/0",
                            m_done.size(), m_done_rv, m_ic_err, m_dc_rd.size());
        end else begin
            total++;
            if (m_done[0] != 0) begin bad++; $display("FAIL irefill_who got=D want=I"); end
        end
    endtask

    task automatic test_d_writeback();
        logic [31:0] exp_a [4] = '{32'h2000, 32'h2004, 32'h2008, 32'h200C};
        logic [31:0] exp_w [4] = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
        bus.dc_addr = 32'h0000_2008;
        bus.dc_we   = 1'b1;
        bus.dc_req  = 1'b1;
        run(12, 0, 1);
        total++;
        if (m_addr.size() != 4) begin
            bad++; $display("FAIL dwb_count en=%0d want 4", m_addr.size());
        end
        for (int k = 0; k < 4 && k < m_addr.size(); k++) begin
            total++;
            if (m_addr[k] !== exp_a[k] || m_wdata[k] !== exp_w[k]) begin
                bad++; $display("FAIL dwb_beat%0d addr=%h wdata=%h want %h/%h", k, m_addr[k], m_wdata[k], exp_a[k], exp_w[k]);
            end
        end
        total++;
        if (m_oe1 != 4 || m_rw1 != 0) begin
            bad++; $display("FAIL dwb_dir oe1=%0d rw1=%0d want 4/0", m_oe1, m_rw1);
        end
        total++;
        if (m_done.size() != 1 || m_dc_rd.size() != 0 || m_ic_rd.size() != 0 || m_dc_err != 0) begin
            bad++; $display("FAIL dwb_done dones=%0d dcrv=%0d icrv=%0d err=%0d want 1/0/0/0",
                            m_done.size(), m_dc_rd.size(), m_ic_rd.size(), m_dc_err);
        end
        total++;
        if (bus.mem_oe !== 1'b0 || bus.mem_rw !== 1'b1 || bus.mem_wdata !== 32'h0) begin
            bad++; $display("FAIL dwb_idle oe=%b rw=%b wdata=%h want 0/1/0", bus.mem_oe, bus.mem_rw, bus.mem_wdata);
        end
        bus.dc_we = 1'b0;
    endtask

    task automatic test_grant_order();
        int exp_o [6] = '{1, 1, 0, 1, 1, 0};
        bus.ic_addr = 32'h0000_4000;
        bus.dc_addr = 32'h0000_5000;
        bus.ic_req  = 1'b1;
        bus.dc_req  = 1'b1;
        run(40, 0, 6);
        total++;
        if (m_done.size() != 6 || m_ic_rd.size() != 8 || m_dc_rd.size() != 16) begin
            bad++; $display("FAIL order_count dones=%0d icrv=%0d dcrv=%0d want 6/8/16",
                            m_done.size(), m_ic_rd.size(), m_dc_rd.size());
        end
        for (int k = 0; k < 6 && k < m_done.size(); k++) begin
            total++;
            if (m_done[k] != exp_o[k]) begin
                bad++; $display("FAIL order_grant%0d got=%s want=%s", k, m_done[k] ? "D" : "I", exp_o[k] ? "D" : "I");
            end
        end
    endtask

    task automatic test_wait_states();
        logic [31:0] exp_a [4] = '{32'h3010, 32'h3014, 32'h3018, 32'h301C};
        bus.dc_addr = 32'h0000_301C;
        bus.dc_req  = 1'b1;
        run(24, 1, 1);
        total++;
        if (m_addr.size() != 16 || m_dc_rd.size() != 4) begin
            bad++; $display("FAIL wait_count en=%0d rv=%0d want 16/4", m_addr.size(), m_dc_rd.size());
        end
        for (int i = 0; i < 16 && i < m_addr.size(); i++) begin
            total++;
            if (m_addr[i] !== exp_a[i/4]) begin
                bad++; $display("FAIL wait_addr cyc%0d got=%h want=%h", i, m_addr[i], exp_a[i/4]);
            end
        end
        for (int k = 0; k < 4 && k < m_dc_rd.size(); k++) begin
            total++;
            if (m_dc_rd[k] !== (32'hD000_0000 ^ exp_a[k])) begin
                bad++; $display("FAIL wait_rdata%0d got=%h want=%h", k, m_dc_rd[k], 32'hD000_0000 ^ exp_a[k]);
            end
        end
        total++;
        if (m_done.size() != 1 || m_dc_err != 0 || m_done_rv != 1) begin
            bad++; $display("FAIL wait_done dones=%0d err=%0d done_with_rv=%0d want 1/0/1", m_done.size(), m_dc_err, m_done_rv);
        end
        bus.mem_ready = 1'b1;
    endtask

    task automatic test_timeout();
        bus.dc_addr = 32'h0000_6004;
        bus.dc_req  = 1'b1;
        run(14, 2, 1);
        total++;
        if (m_addr.size() != 8) begin
            bad++; $display("FAIL tmo_en_cycles got=%0d want=8", m_addr.size());
        end
        for (int i = 0; i < m_addr.size(); i++) begin
            total++;
            if (m_addr[i] !== 32'h6000) begin
                bad++; $display("FAIL tmo_addr cyc%0d got=%h want=00006000", i, m_addr[i]);
            end
        end
        total++;
        if (m_dc_err != 1 || m_err_alone != 0 || m_done.size() != 1 || m_dc_rd.size() != 0) begin
            bad++; $display("FAIL tmo_abort err=%0d err_alone=%0d dones=%0d dcrv=%0d want 1/0/1/0",
                            m_dc_err, m_err_alone, m_done.size(), m_dc_rd.size());
        end
        bus.ic_addr = 32'h0000_7008;
        bus.ic_req  = 1'b1;
        run(12, 0, 1);
        total++;
        if (m_addr.size() != 4 || m_ic_rd.size() != 4 || m_ic_err != 0 || m_done.size() != 1) begin
            bad++; $display("FAIL tmo_recover en=%0d rv=%0d err=%0d dones=%0d want 4/4/0/1",
                            m_addr.size(), m_ic_rd.size(), m_ic_err, m_done.size());
        end else begin
            total++;
            if (m_addr[3] !== 32'h700C || m_ic_rd[3] !== (32'hD000_0000 ^ 32'h700C)) begin
                bad++; $display("FAIL tmo_recover_last addr=%h rd=%h want 0000700c/d000700c", m_addr[3], m_ic_rd[3]);
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        bit found = 1'b0;
        bus.ic_addr   = 32'h0000_1234;
        bus.ic_req    = 1'b1;
        bus.mem_ready = 1'b1;
        for (int c = 0; c < 10 && !found; c++) begin
            @(negedge clk);
            if (bus.mem_en && bus.beat == 2'd2) found = 1'b1;
        end
        total++;
        if (!found) begin bad++; $display("FAIL rstmid_reach_beat2 got=0 want=1"); end
        rst        = 1'b1;
        bus.ic_req = 1'b0;
        @(negedge clk);
        total++;
        if ({bus.mem_en, bus.mem_oe, bus.mem_rw, bus.ic_rvalid, bus.ic_done, bus.ic_err,
             bus.dc_rvalid, bus.dc_done, bus.dc_err} !== 9'b001000000) begin
            bad++;
            $display("FAIL rstmid_ctrl got=%b want=001000000", {bus.mem_en, bus.mem_oe, bus.mem_rw,
                     bus.ic_rvalid, bus.ic_done, bus.ic_err, bus.dc_rvalid, bus.dc_done, bus.dc_err});
        end
        total++;
        if ({bus.mem_addr, bus.mem_wdata, bus.ic_rdata, bus.dc_rdata} !== 128'h0 || bus.beat !== 2'd0) begin
            bad++;
            $display("FAIL rstmid_data addr=%h wdata=%h icrd=%h dcrd=%h beat=%0d want all 0",
                     bus.mem_addr, bus.mem_wdata, bus.ic_rdata, bus.dc_rdata, bus.beat);
        end
        rst = 1'b0;
        run(4, 0, 1);
        total++;
        if (m_done.size() != 0 || m_addr.size() != 0) begin
            bad++; $display("FAIL rstmid_quiet dones=%0d en=%0d want 0/0", m_done.size(), m_addr.size());
        end
        bus.dc_addr = 32'h0000_8000;
        bus.ic_req  = 1'b1;
        bus.dc_req  = 1'b1;
        run(10, 0, 1);
        total++;
        if (m_done.size() != 1 || m_addr.size() != 4) begin
            bad++; $display("FAIL rstmid_regrant dones=%0d en=%0d want 1/4", m_done.size(), m_addr.size());
        end else begin
            total++;
            if (m_done[0] != 1 || m_addr[0] !== 32'h8000) begin
                bad++; $display("FAIL rstmid_d_first who=%s addr=%h want D/00008000", m_done[0] ? "D" : "I", m_addr[0]);
            end
        end
    endtask

    initial begin
        bus.ic_req    = 1'b0;
        bus.ic_addr   = '0;
        bus.dc_req    = 1'b0;
        bus.dc_we     = 1'b0;
        bus.dc_addr   = '0;
        bus.mem_ready = 1'b0;
        test_reset();
        test_i_refill();
        test_d_writeback();
        test_grant_order();
        test_wait_states();
        test_timeout();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Arbitrates the single external memory port of the RV32I SoC between the instruction-cache refill path (read-only) and the data-cache refill/writeback path (read/write). Each grant runs an aligned burst of BURST_LEN words over a ready-handshaked bus, with a per-beat timeout and a starvation guard for instruction fetch. It sits between the two caches and the top-level memory pads; the bidirectional data pad is built at the top from mem_wdata, mem_rdata and mem_oe.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, word width
- BURST_LEN, 4, words per transaction (power of two, ≥2)
- TIMEOUT, 255, max cycles a beat may wait for mem_ready
- MAX_D_STREAK, 2, consecutive D grants allowed while I is waiting

- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- ic_req  in  1  I-cache line read request, held until ic_done
- ic_addr  in  ADDR_W  any address within the requested line
- ic_rdata  out  DATA_W  read word
- ic_rvalid  out  1  ic_rdata valid, one-cycle pulse per beat
- ic_done / ic_err  out  1  completion / timeout-abort pulses
- dc_req  in  1  D-cache request, held until dc_done
- dc_we  in  1  1 = line writeback, 0 = line refill
- dc_addr  in  ADDR_W  any address within the line
- dc_wdata  in  DATA_W  write word selected by beat (combinational from D-cache)
- dc_rdata, dc_rvalid, dc_done, dc_err  out  as the I-cache equivalents
- beat  out  log2(BURST_LEN)  index of current beat within the granted burst
- mem_addr  out  ADDR_W  byte address of current beat
- mem_wdata  out  DATA_W  write data (= dc_wdata during write grant, else 0)
- mem_rdata  in  DATA_W  read data from memory
- mem_rw  out  1  1 = read, 0 = write
- mem_en  out  1  beat request
- mem_oe  out  1  drive data pad (high only during write grant with mem_en)
- mem_ready  in  1  memory accepted/completed current beat

## Operation
- States: IDLE, BURST, DONE.
- IDLE: if any request, arbitrate, latch base = addr with low log2(BURST_LEN)+2 bits cleared, latch direction, beat=0, go BURST.
- Arbitration: D wins unless ic_req high and d_streak == MAX_D_STREAK. d_streak increments on D grant while ic_req high; clears on I grant or when ic_req low at arbitration; saturates at MAX_D_STREAK.
- BURST: mem_en=1, mem_addr = base + 4*beat; beat completes on any edge where mem_en && mem_ready.
- Read beat completion: capture mem_rdata into granted requester's rdata, pulse its rvalid next cycle.
- Last beat (beat == BURST_LEN-1) completes: go DONE. Addresses never leave the line.
- DONE (one cycle): mem_en=0, done pulses for granted requester (concurrent with final rvalid on reads), then IDLE.
- Timeout: wait counter clears at each beat start, increments each BURST cycle without mem_ready; at TIMEOUT, abort: mem_en drops, err and done pulse together in DONE, no further rvalid.
- Request deasserted mid-burst: ignored, burst completes. Requests changing addr mid-burst ignored (latched).
- Reset (any state): next edge returns to IDLE, d_streak=0, burst discarded; requesters re-issue.

## Timing
- Reset values: mem_en=0, mem_oe=0, mem_rw=1, mem_addr=0, mem_wdata=0, beat=0, all rdata=0, all rvalid/done/err=0.
- All outputs registered except mem_wdata (passes dc_wdata).
- req sampled high at edge N → mem_en high from cycle after N, first beat address valid same cycle.
- Zero-wait memory (mem_ready always 1): BURST_LEN cycles of mem_en, one DONE cycle, one IDLE cycle; 4-beat transaction = 6 cycles req-to-next-grant.
- Minimum one IDLE cycle between transactions; back-to-back requests re-arbitrated there.
- Both requests in same IDLE cycle: rule above decides; loser waits, req held.

## Test plan
- Single I refill, ic_addr=0x0000_1234, mem_ready=1 → mem_addr 0x1230,0x1234,0x1238,0x123C; four ic_rvalid pulses with mem_rdata values; ic_done with last rvalid; mem_rw=1, mem_oe=0.
- D writeback dc_addr=0x2008, dc_wdata = 0xA0+beat → mem_wdata 0xA0..0xA3 at 0x2000..0x200C, mem_oe=1, mem_rw=0, dc_done once.
- Both requesting continuously, MAX_D_STREAK=2 → grant order D,D,I,D,D,I.
- mem_ready low 3 cycles per beat → each beat extended by 3, mem_addr stable while waiting, no timeout.
- mem_ready stuck low, TIMEOUT=8 → after 8 wait cycles mem_en drops, dc_err and dc_done pulse once, no dc_rvalid, next request serviced normally.
- rst asserted during beat 2 of I refill → next cycle all outputs at reset values, no ic_done; post-reset D request granted with d_streak=0.
